// File: rtl/me_pkg.sv
// me_pkg: shared state encoding and default geometry for the operand loader.
package me_pkg;
    localparam int K_DEF = 128;
    localparam int N_DEF = 32;
    localparam int START_GAP_DEF = 10;
    typedef enum logic [2:0] {IDLE, START, GAP, SEND, WAIT_RES, DRAIN} state_t;
endpackage

// File: rtl/me_operand_ram.sv
// me_operand_ram: simple dual-port operand buffer with registered read data.
module me_operand_ram #(
    parameter int W = 256,
    parameter int D = 32,
    parameter int AW = (D > 1) ? $clog2(D) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [D];
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/me_operand_loader.sv
// me_operand_loader: buffers an N-word x/y operand pair, then replays it to the
// exponentiation core after a start pulse and waits out the result stream.
module me_operand_loader
    import me_pkg::*;
#(
    parameter int K = K_DEF,
    parameter int N = N_DEF,
    parameter int START_GAP = START_GAP_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [K-1:0] s_x,
    input  logic [K-1:0] s_y,
    input  logic         s_valid,
    output logic         s_ready,
    output logic         me_start,
    output logic [K-1:0] me_x,
    output logic [K-1:0] me_y,
    output logic         me_x_valid,
    output logic         me_y_valid,
    input  logic         me_valid,
    output logic         busy
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] WR_LAST = AW'(N - 1);
    localparam logic [31:0] GAP_LAST = (START_GAP > 0) ? 32'(START_GAP - 1) : 32'd0;
    localparam logic [31:0] SEND_LAST = 32'(N);
    localparam logic [31:0] DRAIN_LAST = (N > 1) ? 32'(N - 2) : 32'd0;

    state_t         state;
    logic [AW-1:0]  wr_idx;
    logic [31:0]    cnt;
    logic [2*K-1:0] rd_data;
    logic [AW-1:0]  rd_addr;
    logic           accept;
    logic           beat;

    assign s_ready = state == IDLE;
    assign accept = s_valid && s_ready;
    assign busy = state != IDLE;
    assign me_start = state == START;
    assign beat = state == SEND;
    assign me_x_valid = beat;
    assign me_y_valid = beat;
    // Address runs one word ahead of the beat so the registered read keeps SEND contiguous.
    assign rd_addr = beat ? AW'(cnt + 32'd1) : '0;
    assign {me_x, me_y} = (beat && cnt != SEND_LAST) ? rd_data : '0;

    me_operand_ram #(.W(2 * K), .D(N), .AW(AW)) u_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_idx),
        .wr_data ({s_x, s_y}),
        .rd_en   (state inside {START, GAP, SEND}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wr_idx <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    wr_idx <= (wr_idx == WR_LAST) ? '0 : wr_idx + 1'b1;
                    if (wr_idx == WR_LAST) state <= START;
                end
                START: begin
                    cnt <= '0;
                    state <= (START_GAP == 0) ? SEND : GAP;
                end
                GAP: begin
                    cnt <= (cnt == GAP_LAST) ? '0 : cnt + 32'd1;
                    if (cnt == GAP_LAST) state <= SEND;
                end
                SEND: begin
                    cnt <= (cnt == SEND_LAST) ? '0 : cnt + 32'd1;
                    if (cnt == SEND_LAST) state <= WAIT_RES;
                end
                WAIT_RES: if (me_valid) begin
                    cnt <= '0;
                    state <= (N > 1) ? DRAIN : IDLE;
                end
                DRAIN: begin
                    cnt <= (cnt == DRAIN_LAST) ? '0 : cnt + 32'd1;
                    if (cnt == DRAIN_LAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_me_operand_loader.sv
// tb_me_operand_loader: table-driven load/replay checks plus reset corner sequences.
module tb_me_operand_loader;
    localparam int K = 128;
    localparam int N = 32;
    localparam int G = 10;

    typedef struct {
        logic [K-1:0] base;
        bit inv, tog, spur, hold;
        int mvd;
        int start_lat;
        int beat_lat;
    } vec_t;

    logic clk = 0, rst_n = 0;
    logic [K-1:0] s_x = '0, s_y = '0;
    logic s_valid = 0, me_valid = 0;
    logic s_ready, me_start, me_x_valid, me_y_valid, busy;
    logic [K-1:0] me_x, me_y;

    me_operand_loader #(.K(K), .N(N), .START_GAP(G)) dut (
        .clk(clk), .rst_n(rst_n), .s_x(s_x), .s_y(s_y), .s_valid(s_valid),
        .s_ready(s_ready), .me_start(me_start), .me_x(me_x), .me_y(me_y),
        .me_x_valid(me_x_valid), .me_y_valid(me_y_valid), .me_valid(me_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    logic [K-1:0] ex [N];
    logic [K-1:0] ey [N];

    task automatic chk(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [K-1:0] mk_y(input logic [K-1:0] x, input bit inv);
        return inv ? ~x : ((x << 4) ^ K'(5));
    endfunction

    // Presents cnt words; only beats seen with s_ready high are recorded in the model.
    task automatic load(input logic [K-1:0] base, input bit inv, input bit tog, input int cnt, output int tl);
        bit ph = 0;
        int i = 0;
        int guard = 0;
        tl = -1;
        while (i < cnt && guard < 4 * N) begin
            @(negedge clk);
            guard++;
            ph = !ph;
            s_valid = !tog || ph;
            s_x = s_valid ? base + K'(i + 1) : '1;
            s_y = s_valid ? mk_y(s_x, inv) : '1;
            if (s_valid && s_ready) begin
                ex[i] = s_x;
                ey[i] = s_y;
                tl = cyc;
                i++;
            end
        end
        chk("load_count", K'(i), K'(cnt));
        @(posedge clk);
        #1 s_valid = 0;
    endtask

    task automatic run_op(input int tl, input vec_t v);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!me_start && t < 20);
        chk("start_lat", K'(cyc - tl), K'(v.start_lat));
        @(negedge clk);
        chk("start_width", K'(me_start), '0);
        if (v.hold) begin
            s_valid = 1;
            s_x = '1;
            s_y = '1;
        end
        if (v.spur) begin
            me_valid = 1;
            @(negedge clk);
            me_valid = 0;
        end
        t = 0;
        while (!me_x_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("beat_lat", K'(cyc - tl), K'(v.beat_lat));
        for (int b = 0; b <= N; b++) begin
            if (b > 0) @(negedge clk);
            chk("beat_valid", K'({me_x_valid, me_y_valid}), K'(3));
            if (b < N) begin
                chk("beat_x", me_x, ex[b]);
                chk("beat_y", me_y, ey[b]);
            end else begin
                chk("guard_x", me_x, '0);
                chk("guard_y", me_y, '0);
            end
        end
        @(negedge clk);
        chk("post_valid", K'({me_x_valid, me_y_valid}), '0);
        chk("post_x", me_x, '0);
        chk("post_busy", K'(busy), K'(1));
        chk("post_ready", K'(s_ready), '0);
        repeat (v.mvd) @(negedge clk);
        chk("wait_busy", K'(busy), K'(1));
        chk("wait_ready", K'(s_ready), '0);
        me_valid = 1;
        s_valid = 0;
        s_x = '0;
        s_y = '0;
        repeat (N - 1) @(negedge clk);
        chk("drain_ready", K'(s_ready), '0);
        @(negedge clk);
        chk("idle_ready", K'(s_ready), K'(1));
        chk("idle_busy", K'(busy), '0);
        me_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [4];
        vec_t v;
        int tl;
        int t;
        vecs[0] = '{base: '0, inv: 1, tog: 0, spur: 0, hold: 0, mvd: 5, start_lat: 1, beat_lat: 2 + G};
        vecs[1] = '{base: '0, inv: 1, tog: 1, spur: 0, hold: 0, mvd: 0, start_lat: 1, beat_lat: 2 + G};
        vecs[2] = '{base: K'(1000), inv: 0, tog: 0, spur: 0, hold: 1, mvd: 3, start_lat: 1, beat_lat: 2 + G};
        vecs[3] = '{base: {32'hA5A5_0000, 96'h0}, inv: 0, tog: 1, spur: 1, hold: 0, mvd: 500, start_lat: 1, beat_lat: 2 + G};

        repeat (3) @(negedge clk);
        chk("rst_busy", K'(busy), '0);
        chk("rst_start", K'(me_start), '0);
        chk("rst_valid", K'({me_x_valid, me_y_valid}), '0);
        chk("rst_x", me_x, '0);
        chk("rst_y", me_y, '0);
        rst_n = 1;
        @(negedge clk);
        chk("rst_ready", K'(s_ready), K'(1));

        for (int i = 0; i < 4; i++) begin
            load(vecs[i].base, vecs[i].inv, vecs[i].tog, N, tl);
            run_op(tl, vecs[i]);
        end

        // Partial load abandoned by reset must not shift the next load.
        v = vecs[0];
        load(K'('h300), 0, 0, 5, tl);
        rst_n = 0;
        #1 chk("partial_rst_busy", K'(busy), '0);
        @(negedge clk);
        rst_n = 1;
        load(K'('h400), 0, 0, N, tl);
        run_op(tl, v);

        // Reset during SEND at beat 5.
        load(K'('h500), 1, 0, N, tl);
        t = 0;
        while (!me_x_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        chk("beat5_x", me_x, ex[5]);
        #2 rst_n = 0;
        #1;
        chk("send_rst_valid", K'({me_x_valid, me_y_valid}), '0);
        chk("send_rst_x", me_x, '0);
        chk("send_rst_y", me_y, '0);
        chk("send_rst_busy", K'(busy), '0);
        chk("send_rst_start", K'(me_start), '0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("send_rst_ready", K'(s_ready), K'(1));
        load(K'('h600), 0, 1, N, tl);
        run_op(tl, v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/me_operand_loader.md
ME_OPERAND_LOADER -- requirements
Module: me_operand_loader

Interface
REQ-001 SHALL have parameter K, default 128, operand word width in bits.
REQ-002 SHALL have parameter N, default 32, number of K-bit words per operand.
REQ-003 SHALL have parameter START_GAP, default 10, idle cycles between the me_start pulse and the first operand beat.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port s_x  input  K  upstream x word, least significant word first.
REQ-007 SHALL have port s_y  input  K  upstream y word, same index as s_x.
REQ-008 SHALL have port s_valid  input  1  s_x/s_y valid.
REQ-009 SHALL have port s_ready  output  1  loader accepts the word pair.
REQ-010 SHALL have port me_start  output  1  one-cycle start pulse to the exponentiation core.
REQ-011 SHALL have ports me_x, me_y  output  K  operand words to the core.
REQ-012 SHALL have ports me_x_valid, me_y_valid  output  1  operand beat valid, always equal.
REQ-013 SHALL have port me_valid  input  1  core result-stream valid, first result word.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, START, GAP, SEND, WAIT_RES, DRAIN.
REQ-016 IDLE: s_ready=1; each s_valid&s_ready beat stores the pair at write index wr_idx (0..N-1), then increments wr_idx.
REQ-017 Acceptance of the beat with wr_idx=N-1 SHALL move to START next cycle and clear wr_idx; s_ready SHALL be 0 from that next cycle until IDLE is re-entered.
REQ-018 START: me_start=1 for exactly one cycle, then GAP.
REQ-019 GAP: counts START_GAP cycles with all me_* outputs 0, then SEND.
REQ-020 SEND: N+1 consecutive beats with no bubbles; beat i (0..N-1) carries stored word i; beat N carries all-zero words (guard word); valids high on every SEND beat.
REQ-021 After beat N, me_x/me_y/valids SHALL return to 0 and state SHALL be WAIT_RES.
REQ-022 WAIT_RES: waits for me_valid=1 (no timeout), then DRAIN.
REQ-023 DRAIN: counts N-1 further cycles (core streams N result words total), then IDLE; s_ready rises on the first IDLE cycle.
REQ-024 me_valid outside WAIT_RES SHALL be ignored.
REQ-025 s_valid while s_ready=0 SHALL not store data or alter any counter.
REQ-026 Latency: last upstream acceptance at cycle t gives me_start at t+1 and first operand beat at t+2+START_GAP.
REQ-027 START_GAP=0 SHALL go START directly to SEND.
REQ-028 Operand buffer SHALL be written only in IDLE and read only in SEND; stored operand persists until overwritten.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, wr_idx=0, all counters 0, me_start=0, me_x=me_y=0, valids=0, busy=0; s_ready=1 once rst_n is high.
REQ-030 Reset mid-operation (any state) SHALL abandon the operation; partially loaded words are discarded logically (wr_idx=0); buffer contents need not be cleared.

Structure
REQ-031 Package me_pkg SHALL hold the state enum type and default K, N, START_GAP constants.
REQ-032 Operand storage SHALL be a sub-module me_operand_ram: simple dual-port, depth N, width 2K, synchronous read; SEND read address SHALL be issued one cycle ahead to keep beats contiguous.

Verification
REQ-033 Load x=word index i+1, y=~(i+1) for i=0..31 with continuous s_valid -> me_start one cycle after 32nd accept, first beat 11 cycles later, beats 1..32 match, beat 33 zero.
REQ-034 Upstream s_valid toggling every other cycle -> same SEND sequence as REQ-033; no word lost or duplicated.
REQ-035 s_valid held high during SEND and WAIT_RES -> s_ready=0, no buffer writes; next load after DRAIN uses fresh data.
REQ-036 me_valid pulsed during GAP, then real me_valid 500 cycles after SEND -> spurious pulse ignored; IDLE exactly 32 cycles after real me_valid.
REQ-037 rst_n asserted in SEND at beat 5 -> outputs 0 immediately, IDLE after release; full reload of 32 new words produces correct stream.
REQ-038 End-to-end with me_iddmm_top (K=128, N=32) and 4096-bit golden operands -> collected 32 result words equal the golden 4096-bit result.
